// File: rtl/mips_step_ctrl_pkg.sv
// Shared definitions for the mips run/single-step controller: FSM state encoding
// and sizing helpers used by the filter and the top level.
package mips_step_ctrl_pkg;

  // Encoding shared with the core debug logic and benches.
  localparam logic [1:0] ST_HOLD   = 2'd0;
  localparam logic [1:0] ST_BURST  = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  typedef enum logic [1:0] {
    StHold   = ST_HOLD,
    StBurst  = ST_BURST,
    StRun    = ST_RUN,
    StHalted = ST_HALTED
  } step_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(int unsigned n);
    int unsigned w;
    w = 1;
    while ((n > 1) && ((32'd1 << w) < n)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/mips_input_filter.sv
// Two-flop synchroniser followed by a debounce counter: a new level is accepted
// only after it has been seen for DEBOUNCE_CYCLES consecutive synchronised samples.
module mips_input_filter
  import mips_step_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic filt
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            s1_q;
  logic            s2_q;
  logic            filt_q, filt_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (s2_q != filt_q) begin
      if (cnt_q == CntMax) begin
        filt_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= in;
      s2_q   <= s1_q;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt = filt_q;

endmodule

// File: rtl/mips_step_ctrl.sv
// Run/single-step controller for the mips core: filters the mode and step inputs,
// drives the core clock enable, latches halt requests and counts enabled cycles.
module mips_step_ctrl
  import mips_step_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 2,
  parameter int unsigned STEP_BURST      = 1,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             change,
  input  logic             step,
  input  logic             halt,
  output logic             cpu_en,
  output logic             mode_step,
  output logic             halted,
  output logic [CNT_W-1:0] step_count
);

  localparam int unsigned BcntW = cnt_width(STEP_BURST);
  localparam logic [BcntW-1:0] BurstLast = BcntW'(STEP_BURST - 1);

  logic change_filt;
  logic step_filt;
  logic step_filt_q;
  logic step_rise;

  step_state_e      state_q, state_d;
  logic [BcntW-1:0] bcnt_q, bcnt_d;
  logic             cpu_en_q, cpu_en_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  mips_input_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_change_filter (
    .clock(clock),
    .reset(reset),
    .in   (change),
    .filt (change_filt)
  );

  mips_input_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_filter (
    .clock(clock),
    .reset(reset),
    .in   (step),
    .filt (step_filt)
  );

  assign step_rise = step_filt & ~step_filt_q;

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    unique case (state_q)
      StHold: begin
        // Mode is checked first so a step edge cannot sneak a burst into run mode.
        if (!change_filt) begin
          state_d = halt ? StHalted : StRun;
        end else if (step_rise) begin
          state_d = StBurst;
          bcnt_d  = BurstLast;
        end
      end
      StBurst: begin
        if (halt || (bcnt_q == '0)) begin
          state_d = StHold;
        end else begin
          bcnt_d = bcnt_q - 1'b1;
        end
      end
      StRun: begin
        if (halt) begin
          state_d = StHalted;
        end else if (change_filt) begin
          state_d = StHold;
        end
      end
      StHalted: begin
        if (change_filt) begin
          state_d = StHold;
        end
      end
      default: state_d = StHold;
    endcase
  end

  always_comb begin
    cpu_en_d = (state_d == StBurst) || (state_d == StRun);
    halted_d = (state_d == StHalted);
    cnt_d    = cpu_en_q ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StHold;
      bcnt_q      <= '0;
      cpu_en_q    <= 1'b0;
      halted_q    <= 1'b0;
      cnt_q       <= '0;
      step_filt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      cpu_en_q    <= cpu_en_d;
      halted_q    <= halted_d;
      cnt_q       <= cnt_d;
      step_filt_q <= step_filt;
    end
  end

  assign cpu_en     = cpu_en_q;
  assign mode_step  = change_filt;
  assign halted     = halted_q;
  assign step_count = cnt_q;

endmodule

// File: tb/tb_mips_step_ctrl.sv
// Directed bench for mips_step_ctrl: instance A uses STEP_BURST=1, CNT_W=16;
// instance B uses STEP_BURST=3, CNT_W=4. Both use DEBOUNCE_CYCLES=2 and a 20 ns clock.
module tb_mips_step_ctrl;

  logic        clock;
  logic        rst_a, chg_a, stp_a, hlt_a;
  logic        en_a, ms_a, hd_a;
  logic [15:0] cnt_a;
  logic        rst_b, chg_b, stp_b, hlt_b;
  logic        en_b, ms_b, hd_b;
  logic [3:0]  cnt_b;

  int checks = 0;
  int errors = 0;

  mips_step_ctrl #(
    .DEBOUNCE_CYCLES(2),
    .STEP_BURST     (1),
    .CNT_W          (16)
  ) u_dut_a (
    .clock     (clock),
    .reset     (rst_a),
    .change    (chg_a),
    .step      (stp_a),
    .halt      (hlt_a),
    .cpu_en    (en_a),
    .mode_step (ms_a),
    .halted    (hd_a),
    .step_count(cnt_a)
  );

  mips_step_ctrl #(
    .DEBOUNCE_CYCLES(2),
    .STEP_BURST     (3),
    .CNT_W          (4)
  ) u_dut_b (
    .clock     (clock),
    .reset     (rst_b),
    .change    (chg_b),
    .step      (stp_b),
    .halt      (hlt_b),
    .cpu_en    (en_b),
    .mode_step (ms_b),
    .halted    (hd_b),
    .step_count(cnt_b)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_a = 1'b0; chg_a = 1'b0; stp_a = 1'b0; hlt_a = 1'b0;
    rst_b = 1'b0; chg_b = 1'b1; stp_b = 1'b0; hlt_b = 1'b1;

    // 1. reset, then run mode
    #5;
    chk("a_rst_en", en_a, 0);
    chk("a_rst_cnt", cnt_a, 0);
    #26;
    rst_a = 1'b1;
    chk("a_rel_en", en_a, 0);
    chk("a_rel_halted", hd_a, 0);
    chk("a_rel_mode", ms_a, 0);
    cyc(1);
    chk("a_run_en", en_a, 1);
    chk("a_run_cnt0", cnt_a, 0);
    cyc(4);
    chk("a_run_cnt4", cnt_a, 4);

    // 2. switch to step mode
    chg_a = 1'b1;
    cyc(1);
    chk("a_mode_k1", ms_a, 0);
    cyc(2);
    chk("a_mode_k2", ms_a, 0);
    chk("a_en_k2", en_a, 1);
    cyc(1);
    chk("a_mode_k3", ms_a, 1);
    chk("a_en_k3", en_a, 1);
    cyc(1);
    chk("a_en_k4", en_a, 0);
    chk("a_cnt_k4", cnt_a, 9);
    cyc(3);
    chk("a_cnt_frozen", cnt_a, 9);

    // 3. one press -> one pulse, then a glitch -> nothing
    stp_a = 1'b1;
    cyc(3);
    stp_a = 1'b0;
    chk("a_step_k2", en_a, 0);
    cyc(1);
    chk("a_step_k3", en_a, 0);
    cyc(1);
    chk("a_step_k4", en_a, 1);
    chk("a_step_cnt_before", cnt_a, 9);
    cyc(1);
    chk("a_step_k5", en_a, 0);
    chk("a_step_cnt_after", cnt_a, 10);
    cyc(2);
    stp_a = 1'b1;
    cyc(1);
    stp_a = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      chk("a_glitch_en", en_a, 0);
    end
    chk("a_glitch_cnt", cnt_a, 10);

    // 4. halt from run mode, then recover through step mode
    chg_a = 1'b0;
    cyc(4);
    chk("a_rerun_wait", en_a, 0);
    cyc(1);
    chk("a_rerun_en", en_a, 1);
    hlt_a = 1'b1;
    cyc(1);
    hlt_a = 1'b0;
    chk("a_halt_halted", hd_a, 1);
    chk("a_halt_en", en_a, 0);
    chk("a_halt_cnt", cnt_a, 11);
    cyc(3);
    chk("a_halt_sticky", hd_a, 1);
    chk("a_halt_sticky_en", en_a, 0);
    chg_a = 1'b1;
    cyc(4);
    chk("a_unhalt_mode", ms_a, 1);
    chk("a_unhalt_still", hd_a, 1);
    cyc(1);
    chk("a_unhalt_halted", hd_a, 0);
    chk("a_unhalt_en", en_a, 0);
    stp_a = 1'b1;
    cyc(3);
    stp_a = 1'b0;
    cyc(1);
    chk("a_post_k3", en_a, 0);
    cyc(1);
    chk("a_post_k4", en_a, 1);
    cyc(1);
    chk("a_post_k5", en_a, 0);
    chk("a_post_cnt", cnt_a, 12);

    // B bring-up: step mode, halt held so the controller never enters run
    cyc(1);
    rst_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("b_bring_en", en_b, 0);
    end
    chk("b_bring_halted", hd_b, 0);
    chk("b_bring_mode", ms_b, 1);
    chk("b_bring_cnt", cnt_b, 0);
    hlt_b = 1'b0;

    // 5. three-cycle burst, then a burst aborted by halt
    stp_b = 1'b1;
    cyc(3);
    stp_b = 1'b0;
    cyc(1);
    chk("b_burst_k3", en_b, 0);
    cyc(1);
    chk("b_burst_c1", en_b, 1);
    cyc(1);
    chk("b_burst_c2", en_b, 1);
    cyc(1);
    chk("b_burst_c3", en_b, 1);
    cyc(1);
    chk("b_burst_end", en_b, 0);
    chk("b_burst_cnt", cnt_b, 3);
    stp_b = 1'b1;
    cyc(3);
    stp_b = 1'b0;
    cyc(1);
    chk("b_abort_k3", en_b, 0);
    cyc(1);
    chk("b_abort_c1", en_b, 1);
    cyc(1);
    chk("b_abort_c2", en_b, 1);
    hlt_b = 1'b1;
    cyc(1);
    hlt_b = 1'b0;
    chk("b_abort_en", en_b, 0);
    chk("b_abort_cnt", cnt_b, 5);
    cyc(1);
    chk("b_abort_stays", en_b, 0);

    // 6. reset mid-burst clears without a clock edge
    stp_b = 1'b1;
    cyc(3);
    stp_b = 1'b0;
    cyc(2);
    chk("b_mid_c1", en_b, 1);
    cyc(1);
    chk("b_mid_cnt", cnt_b, 6);
    #5;
    rst_b = 1'b0;
    #1;
    chk("b_async_en", en_b, 0);
    chk("b_async_cnt", cnt_b, 0);
    chk("b_async_mode", ms_b, 0);
    hlt_b = 1'b1;
    cyc(1);
    rst_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("b_rel_en", en_b, 0);
    end
    hlt_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("b_noresume_en", en_b, 0);
    end
    chk("b_noresume_cnt", cnt_b, 0);

    // 7. 4-bit counter wraps in run mode
    chg_b = 1'b0;
    cyc(5);
    chk("b_wrap_en", en_b, 1);
    chk("b_wrap_cnt0", cnt_b, 0);
    cyc(15);
    chk("b_wrap_cnt15", cnt_b, 15);
    cyc(1);
    chk("b_wrap_cnt16", cnt_b, 0);
    cyc(1);
    chk("b_wrap_cnt17", cnt_b, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
